// File: rtl/placement_engine.sv
// Greedy ring-search placer: streams an edge list, places nodes on a grid,
// sums wirelength and answers node-position queries.
// Ports: clk, reset (async, active-low), start;
//   edge_valid/edge_ready/edge_a/edge_b/edge_last stream;
//   busy, done, fail, cost status; qry_node -> qry_x/qry_y/qry_placed.
module placement_engine #(
  parameter int GRID_W    = 8,
  parameter int GRID_H    = 8,
  parameter int N_NODES   = 64,
  parameter int MAX_EDGES = 64,
  parameter int MAX_R     = 3,
  parameter int ANCHOR_X  = GRID_W / 2,
  parameter int ANCHOR_Y  = GRID_H / 2,
  localparam int XW = $clog2(GRID_W),
  localparam int YW = $clog2(GRID_H),
  localparam int NW = $clog2(N_NODES)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          edge_valid,
  output logic          edge_ready,
  input  logic [NW-1:0] edge_a,
  input  logic [NW-1:0] edge_b,
  input  logic          edge_last,
  output logic          busy,
  output logic          done,
  output logic          fail,
  output logic [31:0]   cost,
  input  logic [NW-1:0] qry_node,
  output logic [XW-1:0] qry_x,
  output logic [YW-1:0] qry_y,
  output logic          qry_placed
);

  localparam int NC   = GRID_W * GRID_H;
  localparam int CLRN = (NC > N_NODES) ? NC : N_NODES;
  localparam int CLW  = $clog2(CLRN);
  localparam int GIW  = $clog2(NC);
  localparam int EW   = $clog2(MAX_EDGES + 1);
  localparam int EIW  = $clog2(MAX_EDGES);
  localparam int DW   = $clog2(MAX_R + 1) + 2;
  localparam int AIDX = ANCHOR_Y * GRID_W + ANCHOR_X;
  localparam logic signed [DW-1:0] S1 = DW'(1);
  localparam logic signed [DW-1:0] SRMAX = DW'(MAX_R);

  typedef enum logic [3:0] {
    S_IDLE, S_CLEAR, S_ACCEPT, S_PA, S_PB, S_SRCH,
    S_WRITE, S_STEP, S_EVAL, S_DONE, S_FAIL
  } state_t;

  state_t r_st, w_nxt;

  logic [NC-1:0]      r_grid;
  logic [N_NODES-1:0] r_placed;
  logic [XW-1:0]      r_px [N_NODES];
  logic [YW-1:0]      r_py [N_NODES];
  logic [NW-1:0]      r_ea [MAX_EDGES];
  logic [NW-1:0]      r_eb [MAX_EDGES];

  logic                 r_first, r_elast, r_ret, r_fail;
  logic [NW-1:0]        r_ca, r_cb, r_tgt, r_lastn;
  logic [EW-1:0]        r_ecnt;
  logic [EIW-1:0]       r_ei;
  logic [CLW-1:0]       r_clr;
  logic [XW-1:0]        r_cenx, r_wx;
  logic [YW-1:0]        r_ceny, r_wy;
  logic signed [DW-1:0] r_r, r_dx, r_dy;
  logic [31:0]          r_cost;

  logic signed [31:0] w_cx, w_cy, w_ex, w_ey;
  logic signed [31:0] w_ax, w_ay, w_term;
  logic [GIW-1:0]     w_cidx, w_widx;
  logic               w_inb, w_free, w_endc;
  logic               w_inrow, w_bad;
  logic [NW-1:0]      w_ea, w_eb;

  // candidate cell = search centre + ring offset
  assign w_cx = $signed({{(32-XW){1'b0}}, r_cenx})
              + $signed({{(32-DW){r_dx[DW-1]}}, r_dx});
  assign w_cy = $signed({{(32-YW){1'b0}}, r_ceny})
              + $signed({{(32-DW){r_dy[DW-1]}}, r_dy});
  assign w_inb = (w_cx >= 0) && (w_cx < GRID_W)
              && (w_cy >= 0) && (w_cy < GRID_H);
  assign w_cidx = GIW'(w_cy * GRID_W + w_cx);
  assign w_free = w_inb && !r_grid[w_cidx];
  assign w_widx = GIW'(int'(r_wy) * GRID_W + int'(r_wx));
  assign w_endc = (r_r == SRMAX) && (r_dy == r_r)
               && (r_dx == r_r);
  // rows strictly inside the ring only visit the two edge columns
  assign w_inrow = (r_dy > -r_r) && (r_dy < r_r);

  assign w_bad = ({1'b0, edge_a} >= (NW+1)'(N_NODES))
              || ({1'b0, edge_b} >= (NW+1)'(N_NODES))
              || (r_ecnt == EW'(MAX_EDGES));

  assign w_ea = r_ea[r_ei];
  assign w_eb = r_eb[r_ei];
  assign w_ex = $signed({{(32-XW){1'b0}}, r_px[w_ea]})
              - $signed({{(32-XW){1'b0}}, r_px[w_eb]});
  assign w_ey = $signed({{(32-YW){1'b0}}, r_py[w_ea]})
              - $signed({{(32-YW){1'b0}}, r_py[w_eb]});
  assign w_ax = (w_ex < 0) ? -w_ex : w_ex;
  assign w_ay = (w_ey < 0) ? -w_ey : w_ey;
  assign w_term = (w_ea == w_eb) ? 32'sd0
                : w_ax + w_ay - 32'sd1;

  assign fail = r_fail;
  assign cost = r_cost;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_st <= S_IDLE;
    else        r_st <= w_nxt;
  end

  always_comb begin
    w_nxt      = r_st;
    edge_ready = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    unique case (r_st)
      S_IDLE: begin
        busy = 1'b0;
        if (start) w_nxt = S_CLEAR;
      end
      S_CLEAR:
        if (r_clr == CLW'(CLRN - 1)) w_nxt = S_ACCEPT;
      S_ACCEPT: begin
        edge_ready = 1'b1;
        if (edge_valid) w_nxt = w_bad ? S_FAIL : S_PA;
      end
      S_PA:
        w_nxt = (r_placed[r_ca] || r_first) ? S_PB : S_SRCH;
      S_PB:
        w_nxt = (r_ca == r_cb || r_placed[r_cb])
              ? S_STEP : S_SRCH;
      S_SRCH:
        if (w_free)      w_nxt = S_WRITE;
        else if (w_endc) w_nxt = S_FAIL;
      S_WRITE:
        w_nxt = r_ret ? S_STEP : S_PB;
      S_STEP:
        w_nxt = r_elast ? S_EVAL : S_ACCEPT;
      S_EVAL:
        if (EW'(r_ei) == r_ecnt - EW'(1)) w_nxt = S_DONE;
      S_DONE, S_FAIL: begin
        busy  = 1'b0;
        done  = 1'b1;
        w_nxt = S_IDLE;
      end
      default: begin
        busy  = 1'b0;
        w_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_grid     <= '0;
      r_placed   <= '0;
      r_first    <= 1'b0;
      r_elast    <= 1'b0;
      r_ret      <= 1'b0;
      r_fail     <= 1'b0;
      r_ca       <= '0;
      r_cb       <= '0;
      r_tgt      <= '0;
      r_lastn    <= '0;
      r_ecnt     <= '0;
      r_ei       <= '0;
      r_clr      <= '0;
      r_cenx     <= '0;
      r_ceny     <= '0;
      r_wx       <= '0;
      r_wy       <= '0;
      r_r        <= '0;
      r_dx       <= '0;
      r_dy       <= '0;
      r_cost     <= '0;
      qry_x      <= '0;
      qry_y      <= '0;
      qry_placed <= 1'b0;
    end else begin
      unique case (r_st)
        S_IDLE:
          if (start) begin
            r_fail <= 1'b0;
            r_cost <= '0;
            r_clr  <= '0;
          end
        S_CLEAR: begin
          if (int'(r_clr) < NC)
            r_grid[r_clr[GIW-1:0]] <= 1'b0;
          if (int'(r_clr) < N_NODES)
            r_placed[r_clr[NW-1:0]] <= 1'b0;
          r_clr   <= r_clr + CLW'(1);
          r_first <= 1'b1;
          r_ecnt  <= '0;
        end
        S_ACCEPT:
          if (edge_valid && !w_bad) begin
            r_ca    <= edge_a;
            r_cb    <= edge_b;
            r_elast <= edge_last;
            r_ecnt  <= r_ecnt + EW'(1);
          end
        S_PA:
          if (!r_placed[r_ca]) begin
            if (r_first) begin
              r_grid[AIDX]   <= 1'b1;
              r_placed[r_ca] <= 1'b1;
              r_first        <= 1'b0;
              r_lastn        <= r_ca;
            end else begin
              r_cenx <= r_px[r_lastn];
              r_ceny <= r_py[r_lastn];
              r_tgt  <= r_ca;
              r_ret  <= 1'b0;
              r_r    <= S1;
              r_dx   <= -S1;
              r_dy   <= -S1;
            end
          end
        S_PB:
          if (r_ca != r_cb && !r_placed[r_cb]) begin
            r_cenx <= r_px[r_ca];
            r_ceny <= r_py[r_ca];
            r_tgt  <= r_cb;
            r_ret  <= 1'b1;
            r_r    <= S1;
            r_dx   <= -S1;
            r_dy   <= -S1;
          end
        S_SRCH:
          if (w_free) begin
            r_wx <= w_cx[XW-1:0];
            r_wy <= w_cy[YW-1:0];
          end else if (r_dx == r_r) begin
            if (r_dy == r_r) begin
              r_r  <= r_r + S1;
              r_dy <= -(r_r + S1);
              r_dx <= -(r_r + S1);
            end else begin
              r_dy <= r_dy + S1;
              r_dx <= -r_r;
            end
          end else if (w_inrow && r_dx == -r_r) begin
            r_dx <= r_r;
          end else begin
            r_dx <= r_dx + S1;
          end
        S_WRITE: begin
          r_grid[w_widx]  <= 1'b1;
          r_placed[r_tgt] <= 1'b1;
          r_lastn         <= r_tgt;
        end
        S_STEP:
          r_ei <= '0;
        S_EVAL: begin
          r_cost <= r_cost + w_term;
          r_ei   <= r_ei + EIW'(1);
        end
        default: ;
      endcase
      if (w_nxt == S_FAIL && r_st != S_FAIL) begin
        r_fail <= 1'b1;
        r_cost <= '0;
      end
      if (({1'b0, qry_node} < (NW+1)'(N_NODES))
          && r_placed[qry_node]) begin
        qry_placed <= 1'b1;
        qry_x      <= r_px[qry_node];
        qry_y      <= r_py[qry_node];
      end else begin
        qry_placed <= 1'b0;
        qry_x      <= '0;
        qry_y      <= '0;
      end
    end
  end

  // store contents need no reset; CLEAR invalidates them
  always_ff @(posedge clk) begin
    if (r_st == S_ACCEPT && edge_valid && !w_bad) begin
      r_ea[r_ecnt[EIW-1:0]] <= edge_a;
      r_eb[r_ecnt[EIW-1:0]] <= edge_b;
    end
    if (r_st == S_PA && !r_placed[r_ca] && r_first) begin
      r_px[r_ca] <= XW'(ANCHOR_X);
      r_py[r_ca] <= YW'(ANCHOR_Y);
    end
    if (r_st == S_WRITE) begin
      r_px[r_tgt] <= r_wx;
      r_py[r_tgt] <= r_wy;
    end
  end

endmodule

// File: tb/tb_placement_engine.sv
// Directed bench for placement_engine: default 8x8 instance u0
// and a 3x3 / MAX_R=1 instance u1 for exhaustion and bad ids.
module tb_placement_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        st0, ev0, er0, el0, bz0, dn0, fl0, qp0;
  logic [5:0]  ea0, eb0, qn0;
  logic [2:0]  qx0, qy0;
  logic [31:0] cs0;

  logic        st1, ev1, er1, el1, bz1, dn1, fl1, qp1;
  logic [3:0]  ea1, eb1, qn1;
  logic [1:0]  qx1, qy1;
  logic [31:0] cs1;

  int checks = 0;
  int errors = 0;

  placement_engine u0 (
    .clk(clk), .reset(rst_n), .start(st0),
    .edge_valid(ev0), .edge_ready(er0),
    .edge_a(ea0), .edge_b(eb0), .edge_last(el0),
    .busy(bz0), .done(dn0), .fail(fl0), .cost(cs0),
    .qry_node(qn0), .qry_x(qx0), .qry_y(qy0),
    .qry_placed(qp0)
  );

  placement_engine #(
    .GRID_W(3), .GRID_H(3), .N_NODES(12),
    .MAX_EDGES(16), .MAX_R(1),
    .ANCHOR_X(1), .ANCHOR_Y(1)
  ) u1 (
    .clk(clk), .reset(rst_n), .start(st1),
    .edge_valid(ev1), .edge_ready(er1),
    .edge_a(ea1), .edge_b(eb1), .edge_last(el1),
    .busy(bz1), .done(dn1), .fail(fl1), .cost(cs1),
    .qry_node(qn1), .qry_x(qx1), .qry_y(qy1),
    .qry_placed(qp1)
  );

  typedef struct {
    int d;
    int node;
    int ex;
    int ey;
    int ep;
    bit xy;
  } qv_t;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  function automatic logic rdy(input int d);
    return (d == 0) ? er0 : er1;
  endfunction

  function automatic logic dn(input int d);
    return (d == 0) ? dn0 : dn1;
  endfunction

  task automatic do_start(input int d);
    @(negedge clk);
    if (d == 0) st0 = 1'b1;
    else        st1 = 1'b1;
    @(negedge clk);
    st0 = 1'b0;
    st1 = 1'b0;
  endtask

  task automatic send_edge(input int d, input int a,
                           input int b, input bit last,
                           input int gap);
    int n;
    repeat (gap) @(negedge clk);
    if (d == 0) begin
      ev0 = 1'b1; ea0 = 6'(a); eb0 = 6'(b); el0 = last;
    end else begin
      ev1 = 1'b1; ea1 = 4'(a); eb1 = 4'(b); el1 = last;
    end
    n = 0;
    while (!rdy(d) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) chk("edge_ready_timeout", 0, 1);
    @(negedge clk);
    ev0 = 1'b0;
    ev1 = 1'b0;
    el0 = 1'b0;
    el1 = 1'b0;
  endtask

  task automatic wait_done(input int d, output int pulses,
                           output logic f,
                           output logic [31:0] c,
                           output logic b);
    int n;
    n = 0;
    pulses = 0;
    f = 1'b0;
    c = '0;
    b = 1'b1;
    while (!dn(d) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      chk("done_timeout", 0, 1);
    end else begin
      f = (d == 0) ? fl0 : fl1;
      c = (d == 0) ? cs0 : cs1;
      b = (d == 0) ? bz0 : bz1;
      pulses = 1;
      repeat (4) begin
        @(negedge clk);
        if (dn(d)) pulses++;
      end
    end
  endtask

  task automatic chk_q(input string tag, input qv_t v);
    int x, y, p;
    @(negedge clk);
    if (v.d == 0) qn0 = 6'(v.node);
    else          qn1 = 4'(v.node);
    @(negedge clk);
    if (v.d == 0) begin x = qx0; y = qy0; p = qp0; end
    else          begin x = qx1; y = qy1; p = qp1; end
    chk($sformatf("%s_u%0d_n%0d_placed", tag, v.d, v.node),
        p, v.ep);
    if (v.xy) begin
      chk($sformatf("%s_u%0d_n%0d_x", tag, v.d, v.node),
          x, v.ex);
      chk($sformatf("%s_u%0d_n%0d_y", tag, v.d, v.node),
          y, v.ey);
    end
  endtask

  task automatic chk_run(input string tag, input int d,
                         input int ef, input int ec);
    int pl;
    logic f, b;
    logic [31:0] c;
    wait_done(d, pl, f, c, b);
    chk({tag, "_pulses"}, pl, 1);
    chk({tag, "_fail"}, f, ef);
    chk({tag, "_cost"}, c, ec);
    chk({tag, "_busy_at_done"}, b, 0);
  endtask

  task automatic run_t1(input string tag, input int g1,
                        input int g2);
    qv_t v;
    do_start(0);
    send_edge(0, 0, 1, 1'b0, g1);
    send_edge(0, 1, 2, 1'b1, g2);
    chk_run(tag, 0, 0, 2);
    v = '{0, 1, 3, 3, 1, 1'b1};
    chk_q(tag, v);
    v = '{0, 2, 2, 2, 1, 1'b1};
    chk_q(tag, v);
  endtask

  initial begin
    qv_t tbl [12];
    qv_t v;

    tbl[0]  = '{0, 0,  4, 4, 1, 1'b1};
    tbl[1]  = '{0, 1,  3, 3, 1, 1'b1};
    tbl[2]  = '{0, 2,  2, 2, 1, 1'b1};
    tbl[3]  = '{0, 5,  0, 0, 0, 1'b0};
    tbl[4]  = '{0, 63, 0, 0, 0, 1'b0};
    tbl[5]  = '{1, 0,  1, 1, 1, 1'b1};
    tbl[6]  = '{1, 1,  0, 0, 1, 1'b1};
    tbl[7]  = '{1, 3,  2, 0, 1, 1'b1};
    tbl[8]  = '{1, 4,  0, 1, 1, 1'b1};
    tbl[9]  = '{1, 8,  2, 2, 1, 1'b1};
    tbl[10] = '{1, 9,  0, 0, 0, 1'b0};
    tbl[11] = '{1, 11, 0, 0, 0, 1'b0};

    rst_n = 1'b0;
    st0 = 0; ev0 = 0; el0 = 0; ea0 = 0; eb0 = 0; qn0 = 0;
    st1 = 0; ev1 = 0; el1 = 0; ea1 = 0; eb1 = 0; qn1 = 0;
    repeat (3) @(negedge clk);
    chk("rst_busy", bz0, 0);
    chk("rst_done", dn0, 0);
    chk("rst_fail", fl0, 0);
    chk("rst_cost", cs0, 0);
    chk("rst_ready", er0, 0);
    chk("rst_qplaced", qp0, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // basic two-edge run
    do_start(0);
    send_edge(0, 0, 1, 1'b0, 0);
    send_edge(0, 1, 2, 1'b1, 0);
    chk_run("t1", 0, 0, 2);

    // out-of-range node id on the small instance
    do_start(1);
    send_edge(1, 3, 12, 1'b0, 0);
    chk_run("badid", 1, 1, 0);
    v = '{1, 3, 0, 0, 0, 1'b0};
    chk_q("badid", v);

    // fill every ring cell, then exhaust the search
    do_start(1);
    for (int i = 1; i <= 8; i++)
      send_edge(1, 0, i, 1'b0, 0);
    send_edge(1, 0, 9, 1'b1, 0);
    chk_run("exhaust", 1, 1, 0);

    for (int i = 0; i < 12; i++)
      chk_q("tbl", tbl[i]);

    // valid gaps must not change the result
    for (int g = 0; g < 6; g++)
      run_t1($sformatf("gap%0d", g), g, 5 - g);

    // reset while placing the sink of edge 2
    do_start(0);
    send_edge(0, 0, 1, 1'b0, 0);
    send_edge(0, 1, 2, 1'b1, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", bz0, 0);
    chk("midrst_done", dn0, 0);
    chk("midrst_fail", fl0, 0);
    chk("midrst_cost", cs0, 0);
    chk("midrst_ready", er0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_t1("rerun", 0, 0);

    // lone self-edge lands at the anchor with zero cost
    do_start(0);
    send_edge(0, 4, 4, 1'b1, 0);
    chk_run("self", 0, 0, 0);
    v = '{0, 4, 4, 4, 1, 1'b1};
    chk_q("self", v);
    v = '{0, 0, 0, 0, 0, 1'b0};
    chk_q("self", v);

    // exactly MAX_EDGES edges fit
    do_start(1);
    for (int i = 0; i < 16; i++)
      send_edge(1, 0, 1, (i == 15), 0);
    chk_run("full16", 1, 0, 16);

    // one edge beyond the store without last
    do_start(1);
    for (int i = 0; i < 17; i++)
      send_edge(1, 0, 1, 1'b0, 0);
    chk_run("over17", 1, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
